// File: rtl/ospfb_phasecomp_buf.sv
// Phase-compensation ping-pong buffer between the PFB FIR chain and the FFT.
// Each completed M-sample frame is replayed circularly rotated by s_n = (n*D) mod M.

package ospfb_phasecomp_pkg;
  typedef enum logic {
    FILLA = 1'b0,
    FILLB = 1'b1
  } phasecomp_state_t;
endpackage

module ospfb_phasecomp_buf
  import ospfb_phasecomp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 2048,
  parameter int DEC_FAC = 1536
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WIDTH-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [WIDTH-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(FFT_LEN)-1:0] frame_shift,
  output phasecomp_state_t           state
);
  localparam int AW = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0] DEC_STEP = AW'(DEC_FAC);

  // Both AXI-stream ports: a beat transfers on a rising edge where valid && ready;
  // once m_axis_tvalid is high, data/last hold until that transfer happens.

  phasecomp_state_t state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_k_q, rd_k_d;
  logic [AW-1:0]    shift_q, shift_d;
  logic             pipe_valid_q, pipe_valid_d;
  logic             pipe_last_q, pipe_last_d;
  logic [WIDTH-1:0] pipe_data_q;
  logic             skid_valid_q, skid_valid_d;
  logic             skid_last_q, skid_last_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  logic             wr_bank, rd_bank;
  logic             s_hs, last_wr, issue_en, last_rd, swap;
  logic [AW-1:0]    rd_addr;

  logic [WIDTH-1:0] mem_a [FFT_LEN];
  logic [WIDTH-1:0] mem_b [FFT_LEN];

  always_comb begin
    wr_bank  = (state_q == FILLB);
    rd_bank  = ~wr_bank;
    s_hs     = s_axis_tvalid & s_axis_tready;
    last_wr  = s_hs & (wr_idx_q == LAST_IDX);
    // The skid register, not m_axis_tready, gates new reads so ready never feeds issue.
    issue_en = full_q[rd_bank] & ~skid_valid_q;
    last_rd  = issue_en & (rd_k_q == LAST_IDX);
    rd_addr  = rd_k_q + shift_q;
    swap     = (full_q[wr_bank] | last_wr) & (~full_q[rd_bank] | last_rd);
  end

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    wr_idx_d = wr_idx_q;
    rd_k_d   = rd_k_q;
    shift_d  = shift_q;
    if (swap) state_d = (state_q == FILLA) ? FILLB : FILLA;
    if (last_wr) full_d[wr_bank] = 1'b1;
    if (last_rd) full_d[rd_bank] = 1'b0;
    if (s_hs) wr_idx_d = wr_idx_q + AW'(1);
    if (issue_en) rd_k_d = rd_k_q + AW'(1);
    if (last_rd) shift_d = shift_q + DEC_STEP;
  end

  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_last_d  = pipe_last_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      skid_valid_d = ~m_axis_tready;
    end else begin
      skid_valid_d = pipe_valid_q & ~m_axis_tready;
      skid_last_d  = pipe_last_q;
      skid_data_d  = pipe_data_q;
      pipe_valid_d = issue_en;
      pipe_last_d  = last_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= FILLA;
      full_q       <= '0;
      wr_idx_q     <= '0;
      rd_k_q       <= '0;
      shift_q      <= '0;
      pipe_valid_q <= 1'b0;
      pipe_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_idx_q     <= wr_idx_d;
      rd_k_q       <= rd_k_d;
      shift_q      <= shift_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_last_q  <= pipe_last_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_hs && !wr_bank) mem_a[wr_idx_q] <= s_axis_tdata;
    if (s_hs && wr_bank)  mem_b[wr_idx_q] <= s_axis_tdata;
  end

  // Registered BRAM read port; it holds its word while the skid register is occupied.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_data_q <= '0;
    end else if (issue_en) begin
      pipe_data_q <= rd_bank ? mem_b[rd_addr] : mem_a[rd_addr];
    end
  end

  assign s_axis_tready = rstn & ~full_q[wr_bank];
  assign m_axis_tvalid = skid_valid_q | pipe_valid_q;
  assign m_axis_tdata  = skid_valid_q ? skid_data_q : pipe_data_q;
  assign m_axis_tlast  = skid_valid_q ? skid_last_q : (pipe_valid_q & pipe_last_q);
  assign frame_shift   = shift_q;
  assign state         = state_q;

endmodule

// File: tb/tb_ospfb_phasecomp_buf.sv
// Bench for ospfb_phasecomp_buf: rotation model on M=16/D=12 plus a continuous-flow
// parameter sweep on three further instances.
`timescale 1ns/1ps
module tb_ospfb_phasecomp_buf;
  localparam int W  = 16;
  localparam int M  = 16;
  localparam int D  = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [AW-1:0] frame_shift;
  logic          state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ospfb_phasecomp_buf #(.WIDTH(W), .FFT_LEN(M), .DEC_FAC(D)) u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .frame_shift   (frame_shift),
    .state         (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- clock/cycle bookkeeping and driver ----------------
  int cyc = 0;
  int in_limit = 0;
  int in_mode = 0;   // 0 idle, 1 always valid, 2 random 50%
  int out_mode = 0;  // 0 stalled, 1 always ready, 2 random 50%
  int acc_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_tvalid = (acc_count < in_limit) &&
                 ((in_mode == 1) || ((in_mode == 2) && ($urandom_range(0, 1) == 1)));
      s_tdata  = W'(acc_count);
      m_tready = (out_mode == 1) || ((out_mode == 2) && ($urandom_range(0, 1) == 1));
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_k_q[$];
  int           exp_s_q[$];
  logic [W-1:0] cur_frame[$];
  logic [W-1:0] out_log[$];
  int           shift_log[$];
  int frame_n = 0;
  int out_count = 0;
  int tlast_count = 0;
  int ready_drops = 0;
  int first_valid_cyc = -1;
  int frame0_done_cyc = -1;
  bit stall_test = 0;
  bit drop_armed = 0;
  bit drop_checked = 0;

  always @(negedge clk) begin
    int s;
    int k;
    logic [W-1:0] e;
    if (!rstn) begin
      exp_q.delete(); exp_k_q.delete(); exp_s_q.delete(); cur_frame.delete();
      out_log.delete(); shift_log.delete();
      frame_n = 0; acc_count = 0; out_count = 0; tlast_count = 0;
      first_valid_cyc = -1; frame0_done_cyc = -1; drop_armed = 0;
    end else begin
      if (drop_armed) begin
        check("ready_drop_after_input31", 32'(s_tready), 32'(0));
        drop_armed = 0;
        drop_checked = 1;
      end
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!s_tready) ready_drops++;
      if (s_tvalid && s_tready) begin
        cur_frame.push_back(s_tdata);
        acc_count++;
        if (stall_test && acc_count == 32) drop_armed = 1;
        if (cur_frame.size() == M) begin
          s = (frame_n * D) % M;
          for (int j = 0; j < M; j++) begin
            exp_q.push_back(cur_frame[(j + s) % M]);
            exp_k_q.push_back(j);
            exp_s_q.push_back(s);
          end
          if (frame_n == 0) frame0_done_cyc = cyc;
          frame_n++;
          cur_frame.delete();
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL output_without_input: got data %0d, expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          k = exp_k_q.pop_front();
          s = exp_s_q.pop_front();
          check("out_data", 32'(m_tdata), 32'(e));
          check("out_tlast", 32'(m_tlast), 32'(k == M - 1));
          if (k == 0) begin
            check("frame_shift", 32'(frame_shift), 32'(s));
            shift_log.push_back(int'(frame_shift));
          end
          if (m_tlast) tlast_count++;
          out_log.push_back(m_tdata);
          out_count++;
        end
      end
    end
  end

  task automatic wait_outputs(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (out_count >= n) break;
    end
    checks++;
    if (out_count < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", name, out_count, n);
    end
  endtask

  task automatic wait_accepted(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (acc_count >= n) break;
    end
    checks++;
    if (acc_count < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d inputs, expected %0d", name, acc_count, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    in_mode = 0; out_mode = 0; in_limit = 0;
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag, input logic exp_ready);
    check({tag, "_s_tready"}, 32'(s_tready), 32'(exp_ready));
    check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'(0));
    check({tag, "_m_tlast"}, 32'(m_tlast), 32'(0));
    check({tag, "_m_tdata"}, 32'(m_tdata), 32'(0));
    check({tag, "_frame_shift"}, 32'(frame_shift), 32'(0));
    check({tag, "_state"}, 32'(state), 32'(0));
  endtask

  // ---------------- parameter sweep: continuous flow on other sizes ----------------
  logic sw_rstn = 1'b0;
  initial begin
    repeat (2) @(posedge clk);
    #1 sw_rstn = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SM  = (g == 0) ? 8 : ((g == 1) ? 32 : 2048);
    localparam int SD  = (SM * 3) / 4;
    localparam int SAW = $clog2(SM);
    localparam int NFR = (g == 2) ? 3 : 6;
    logic [W-1:0]   sd = '0;
    logic           sv = 1'b0;
    logic           sr;
    logic [W-1:0]   md;
    logic           mv;
    logic           mr = 1'b1;
    logic           ml;
    logic [SAW-1:0] fs;
    logic           st;
    int  acc = 0;
    int  outs = 0;
    int  bubbles = 0;
    bit  started = 0;
    bit  done = 0;

    ospfb_phasecomp_buf #(.WIDTH(W), .FFT_LEN(SM), .DEC_FAC(SD)) u_sw (
      .clk           (clk),
      .rstn          (sw_rstn),
      .s_axis_tdata  (sd),
      .s_axis_tvalid (sv),
      .s_axis_tready (sr),
      .m_axis_tdata  (md),
      .m_axis_tvalid (mv),
      .m_axis_tready (mr),
      .m_axis_tlast  (ml),
      .frame_shift   (fs),
      .state         (st)
    );

    initial begin
      forever begin
        @(posedge clk);
        #1;
        sv = sw_rstn;
        sd = W'(acc);
      end
    end

    always @(negedge clk) begin
      int n;
      int k;
      int s;
      if (sw_rstn && !done) begin
        if (!sr) bubbles++;
        if (started && !mv) bubbles++;
        if (sv && sr) acc++;
        if (mv) begin
          started = 1;
          n = outs / SM;
          k = outs % SM;
          s = (n * SD) % SM;
          check("sweep_data", 32'(md), 32'(n * SM + (k + s) % SM));
          check("sweep_tlast", 32'(ml), 32'(k == SM - 1));
          if (k == 0) check("sweep_shift", 32'(fs), 32'(s));
          outs++;
          if (outs == SM * NFR) begin
            check("sweep_no_bubble", 32'(bubbles), 32'(0));
            done = 1;
          end
        end
      end
    end
  end

  // ---------------- directed test sequence ----------------
  typedef struct {
    int frame;
    int shift;
    int out0;
    int out1;
    int out4;
  } frame_vec_t;

  frame_vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 0, 0, 1, 4};
    vecs[1] = '{1, 12, 28, 29, 16};
    vecs[2] = '{2, 8, 40, 41, 44};
    vecs[3] = '{3, 4, 52, 53, 56};
    vecs[4] = '{4, 0, 64, 65, 68};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset", 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(s_tready), 32'(1));

    // Continuous ramp, ten frames.
    ready_drops = 0;
    in_limit = 160; in_mode = 1; out_mode = 1;
    wait_outputs(160, 400, "ramp");
    check("ramp_latency", 32'(first_valid_cyc - frame0_done_cyc), 32'(2));
    check("ramp_ready_drops", 32'(ready_drops), 32'(0));
    check("ramp_tlast_count", 32'(tlast_count), 32'(10));
    check("ramp_exp_empty", 32'(exp_q.size()), 32'(0));
    for (int i = 0; i < 5; i++) begin
      if (out_log.size() >= 160 && shift_log.size() >= 5) begin
        check("tbl_shift", 32'(shift_log[vecs[i].frame]), 32'(vecs[i].shift));
        check("tbl_out0", 32'(out_log[vecs[i].frame * M]), 32'(vecs[i].out0));
        check("tbl_out1", 32'(out_log[vecs[i].frame * M + 1]), 32'(vecs[i].out1));
        check("tbl_out4", 32'(out_log[vecs[i].frame * M + 4]), 32'(vecs[i].out4));
      end else begin
        checks++;
        errors++;
        $display("FAIL tbl_frame%0d: got %0d logged outputs, expected 160", i, out_log.size());
      end
    end

    // Output stall of 40 cycles during frame 0.
    do_reset();
    stall_test = 1; drop_checked = 0;
    in_limit = 64; in_mode = 1; out_mode = 1;
    wait_outputs(8, 100, "stall_pre");
    @(posedge clk);
    out_mode = 0;
    repeat (40) @(posedge clk);
    out_mode = 1;
    wait_outputs(64, 300, "stall_post");
    stall_test = 0;
    check("stall_drop_seen", 32'(drop_checked), 32'(1));
    check("stall_out_count", 32'(out_count), 32'(64));
    check("stall_exp_empty", 32'(exp_q.size()), 32'(0));

    // Random valid/ready, twenty frames.
    do_reset();
    in_limit = 320; in_mode = 2; out_mode = 2;
    wait_outputs(320, 5000, "random");
    check("random_out_count", 32'(out_count), 32'(320));
    check("random_tlast_count", 32'(tlast_count), 32'(20));
    check("random_exp_empty", 32'(exp_q.size()), 32'(0));

    // One-cycle reset after input 7 of frame 2.
    do_reset();
    in_limit = 1000; in_mode = 1; out_mode = 1;
    wait_accepted(40, 100, "midreset");
    #1 rstn = 1'b0;
    in_limit = 32;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset", 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_outputs(32, 200, "after_reset");
    if (out_log.size() >= 16 && shift_log.size() >= 1) begin
      check("after_reset_shift0", 32'(shift_log[0]), 32'(0));
      for (int i = 0; i < 16; i++) check("after_reset_order", 32'(out_log[i]), 32'(i));
    end else begin
      checks++;
      errors++;
      $display("FAIL after_reset_log: got %0d outputs, expected 16", out_log.size());
    end

    for (int i = 0; i < 20000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(posedge clk);
    end
    checks++;
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)) begin
      errors++;
      $display("FAIL sweep_timeout: got done %0d%0d%0d, expected 111",
               g_sweep[0].done, g_sweep[1].done, g_sweep[2].done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ospfb_phasecomp_buf.md
# ospfb_phasecomp_buf

Phase-compensation ping-pong buffer for the oversampled PFB. It sits between the polyphase FIR (PE chain) output and the FFT input. It collects one FFT_LEN-sample frame per bank and replays each completed frame circularly rotated by the per-frame offset s_n = (n·DEC_FAC) mod FFT_LEN. This removes the phase ramp that decimation by DEC_FAC < FFT_LEN introduces. Frames are delivered as AXI-stream, with tlast marking each FFT frame boundary.

## Interface
- WIDTH, 16, sample word width (passed through unmodified)
- FFT_LEN, 2048, frame length M; power of two, ≥ 4
- DEC_FAC, 1536, decimation factor D; 0 < D < M
- clk  in  1  DSP clock; all logic on rising edge
- rstn  in  1  reset; one clock, synchronous, active-low
- s_axis_tdata  in  WIDTH  FIR output sample
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  WIDTH  rotated sample to FFT
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  FFT ready
- m_axis_tlast  out  1  high on last sample (k = M−1) of each output frame
- frame_shift  out  $clog2(FFT_LEN)  offset s_n applied to the frame currently being read
- state  out  1  phasecomp_state_t: FILLA (0) when bank A is the write bank, FILLB (1) when bank B is

## Operation
- Two banks A and B, each M×WIDTH (inferred BRAM with 1-cycle registered read). The write bank is selected by state; the read bank is the other one.
- Write side:
  - wr_idx increments on each s_axis handshake and wraps M−1→0.
  - A sample accepted at wr_idx is stored at address wr_idx.
- Per-bank full flag:
  - Set when sample M−1 is written.
  - Cleared when the read side issues its last address (k = M−1).
- State transition FILLA↔FILLB (bank swap) happens when:
  - the write bank becomes full, and
  - the read bank is empty or is issuing its last address in the same cycle.
  - A simultaneous last-write and last-read-issue must swap with no bubble.
- If the write bank is full and the read bank is not yet drained:
  - s_axis_tready = 0 until the swap.
  - No input sample is dropped or overwritten.
- Read side:
  - Starts when the read bank is full.
  - Issues addresses (k + s_n) mod M for k = 0..M−1.
  - Output m_axis_tdata[k] = frame[(k + s_n) mod M].
- Offset s_n:
  - s_0 = 0.
  - After each frame's last read issue, s_{n+1} = (s_n + D) mod M, computed with a plain $clog2(M)-bit wrapping add.
  - frame_shift shows s_n while frame n is being read.
- Backpressure: the read pipeline uses a one-entry skid register, so m_axis_tready may drop at any cycle without data loss or duplication.
- m_axis_tvalid does not depend combinationally on m_axis_tready.

## Timing
- Reset values:
  - s_axis_tready = 0 while rstn = 0, and 1 from the first cycle after release.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - frame_shift = 0, state = FILLA.
  - Both full flags cleared; wr_idx, rd_k = 0.
- Reset mid-frame discards all partially written and unread data. The next accepted sample is wr_idx 0 of frame 0, with s = 0.
- Latency: when the last sample of a frame is accepted at cycle t (read side idle), the first output has m_axis_tvalid = 1 at t+2.
- Throughput: with continuous s_axis_tvalid and m_axis_tready, one sample/cycle in and out. s_axis_tready never drops after the first frame.
- m_axis_tlast is coincident with output k = M−1 only.
- Frames are never interleaved: frame n+1's output starts only after frame n's tlast handshake.

## Test plan
- Bench parameters M=16, D=12. Input is a continuous ramp 0,1,2,…; m_axis_tready=1.
  - Frame 0 out = 0..15 with frame_shift 0.
  - Frame 1 (inputs 16..31) out starts 28,29,30,31,16,… with frame_shift 12.
  - Frame shifts for frames 0..4 are 0,12,8,4,0.
- Same ramp input: first m_axis_tvalid exactly 2 cycles after input 15 is accepted. No s_axis_tready deassertion over 10 frames. tlast every 16th output.
- Hold m_axis_tready=0 for 40 cycles mid-frame 0:
  - s_axis_tready drops after input 31 is accepted.
  - Output resumes with no loss or duplication.
  - After the stall, the output sequence equals the reference model.
- Random tvalid/tready (50% each) for 20 frames: output matches the golden rotation model sample-for-sample; tlast alignment holds.
- Assert rstn=0 for one cycle after input 7 of frame 2:
  - All outputs return to reset values the next cycle.
  - The following frame is treated as frame 0 (shift 0, output = input order).
- Parameter sweep (M=8, D=6; M=32, D=24; M=2048, D=1536): shift sequence and output ordering match the model; no bubble at bank swaps under continuous flow.
